demultiplexador_1x4_16b_hs: RTL and testbench
=============================================

# demultiplexador_1x4_16b_hs

Registered 1-to-4 demultiplexer for 16-bit words with a valid/ready handshake on the input and on each of the four outputs. An input word is steered by a 2-bit selector into a one-word output buffer for the chosen channel, and held there until that channel's consumer accepts it. It is the distribution end of the 4-to-1 16-bit selection path: one producer fans out to four independent consumers. Each channel counts its delivered words.

## Interface
Parameters:
- LARGURA, 16, data width of input and outputs.
- LARGURA_CONTADOR, 8, width of each per-channel delivered-word counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada  input  LARGURA  input data word.
- entrada_controle  input  2  destination channel (2'b00 to 2'b11), qualified by entrada_valida.
- entrada_valida  input  1  producer has a word on entrada.
- entrada_pronta  output  1  block accepts the word this cycle (combinational).
- saida_0..saida_3  output  LARGURA  buffered word for each channel (registered).
- saida_valida_0..saida_valida_3  output  1  channel buffer holds a word (registered).
- saida_pronta_0..saida_pronta_3  input  1  consumer of the channel takes the word this cycle.
- contagem_0..contagem_3  output  LARGURA_CONTADOR  words delivered per channel (registered).

## Operation
- Each channel k has one buffer slot: a data register, a valid flag, and a delivered-word counter.
- Input handshake: a word is accepted when entrada_valida && entrada_pronta.
- entrada_pronta = !saida_valida_sel || saida_pronta_sel, where sel = entrada_controle.
  - It depends only on the selected channel. A full, stalled channel never blocks the other channels.
- Output handshake on channel k: a word is delivered when saida_valida_k && saida_pronta_k.
- Per-channel next state:
  - Accept into k, no delivery: load the data, set valid.
  - Delivery, no accept: clear valid. Data register keeps its last value.
  - Accept and delivery in the same cycle: load the new data, valid stays 1. This gives full throughput, one word per cycle per channel.
  - Neither: hold.
- Counter k increments by 1 on each delivery on channel k. It wraps from 2^LARGURA_CONTADOR-1 to 0 with no saturation or flag.
- entrada_controle and entrada are ignored when entrada_valida = 0.
- Consumer rule: saida_pronta_k is allowed while saida_valida_k = 0 and has no effect.
- Producer rule: once entrada_valida is asserted, entrada and entrada_controle must hold until acceptance. The bench checks this as a protocol assertion; the RTL does not enforce it.

## Timing
- Reset, checked at the clock edge: every saida_k = 0, every saida_valida_k = 0, every contagem_k = 0.
  - entrada_pronta is therefore 1 in the cycle after reset.
- Reset mid-operation: buffered words are discarded and counters cleared. No delivery is signalled during the reset cycle.
- Reset has priority over simultaneous accept and delivery.
- Latency: a word accepted at edge N appears on saida_k with saida_valida_k = 1 after edge N, so one cycle.
- A delivery at edge N clears saida_valida_k after edge N, unless an accept into k happens at the same edge.
- Counter update is visible after the edge of the delivery.
- entrada_pronta is combinational from registered valid flags, the saida_pronta inputs and entrada_controle. There is no path from entrada_valida to entrada_pronta.

## Structure
- Shared package `demux_pkg`:
  - LARGURA_PADRAO = 16.
  - NUM_SAIDAS = 4.
  - Selector width constant = 2.
  - Localparam channel indices CANAL_0..CANAL_3.
- Sub-module `registrador_saida`, instantiated four times. It holds one slot's data register, valid flag and counter, with inputs carregar, pronta, dado and reset.
- The top level contains only the selector decode (one carregar per slot) and the entrada_pronta mux.

## Test plan
- Reset and idle: assert reset for 2 cycles with saida_pronta_* = 0.
  - Expect all saida_valida = 0, saida = 16'h0000 and contagem = 0.
  - Expect entrada_pronta = 1 after reset releases.
- Single routing: send 16'h0001, 16'h0002, 16'h0003, 16'h0004 with controle 00, 01, 10, 11, all consumers ready.
  - Expect each word on its own channel one cycle after acceptance.
  - Expect each contagem_k = 1.
- Back-pressure isolation:
  - Channel 2 full with 16'hBEEF and saida_pronta_2 = 0. Offer 16'h1234 to channel 2: expect entrada_pronta = 0 and saida_2 to stay 16'hBEEF.
  - Switch controle to 01: expect the word accepted on channel 1.
- Simultaneous accept and delivery: channel 0 full, saida_pronta_0 = 1, stream 16'hA000..16'hA009 on controle 00.
  - Expect one word per cycle, saida_valida_0 continuously 1, in order.
  - Expect contagem_0 = 10 after draining.
- Counter wrap: deliver 256 words on channel 3.
  - Expect contagem_3 = 0 after the 256th delivery and 1 after the 257th.
- Reset mid-operation: all four channels full, assert reset for 1 cycle.
  - Expect all valid flags and counters at 0 on the next cycle.
  - Expect no delivery counted even though saida_pronta_* = 1 during the reset cycle.

Source files
------------

// File: rtl/demultiplexador_1x4_16b_hs_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer: widths, channel
// indices and the selector decode.
package demux_pkg;

  localparam int LARGURA_PADRAO          = 16;
  localparam int LARGURA_CONTADOR_PADRAO = 8;
  localparam int NUM_SAIDAS              = 4;
  localparam int LARGURA_SELECAO         = 2;

  localparam logic [LARGURA_SELECAO-1:0] CANAL_0 = 2'd0;
  localparam logic [LARGURA_SELECAO-1:0] CANAL_1 = 2'd1;
  localparam logic [LARGURA_SELECAO-1:0] CANAL_2 = 2'd2;
  localparam logic [LARGURA_SELECAO-1:0] CANAL_3 = 2'd3;

  // One-hot channel decode of the selector.
  function automatic logic [NUM_SAIDAS-1:0] decodificar(input logic [LARGURA_SELECAO-1:0] sel);
    return NUM_SAIDAS'(1) << sel;
  endfunction

endpackage

// File: rtl/demultiplexador_1x4_16b_hs_if.sv
// Producer/consumer bus of the 1-to-4 demultiplexer. master = environment side
// (producer and the four consumers), slave = the demultiplexer.
interface demultiplexador_1x4_16b_hs_if
  import demux_pkg::*;
#(
  parameter int LARGURA          = LARGURA_PADRAO,
  parameter int LARGURA_CONTADOR = LARGURA_CONTADOR_PADRAO
);
  // Handshake: a word moves on a link exactly in a cycle where valid and ready
  // are both 1 at the rising edge; valid never depends on ready, and a raised
  // valid keeps its data stable until that transfer happens.
  logic [LARGURA-1:0]          entrada;
  logic [LARGURA_SELECAO-1:0]  entrada_controle;
  logic                        entrada_valida;
  logic                        entrada_pronta;

  logic [LARGURA-1:0]          saida_0, saida_1, saida_2, saida_3;
  logic                        saida_valida_0, saida_valida_1, saida_valida_2, saida_valida_3;
  logic                        saida_pronta_0, saida_pronta_1, saida_pronta_2, saida_pronta_3;
  logic [LARGURA_CONTADOR-1:0] contagem_0, contagem_1, contagem_2, contagem_3;

  modport master (
    output entrada, entrada_controle, entrada_valida,
    output saida_pronta_0, saida_pronta_1, saida_pronta_2, saida_pronta_3,
    input  entrada_pronta,
    input  saida_0, saida_1, saida_2, saida_3,
    input  saida_valida_0, saida_valida_1, saida_valida_2, saida_valida_3,
    input  contagem_0, contagem_1, contagem_2, contagem_3
  );

  modport slave (
    input  entrada, entrada_controle, entrada_valida,
    input  saida_pronta_0, saida_pronta_1, saida_pronta_2, saida_pronta_3,
    output entrada_pronta,
    output saida_0, saida_1, saida_2, saida_3,
    output saida_valida_0, saida_valida_1, saida_valida_2, saida_valida_3,
    output contagem_0, contagem_1, contagem_2, contagem_3
  );

endinterface

// File: rtl/demultiplexador_1x4_16b_hs_registrador_saida.sv
// One output slot: data register, valid flag and delivered-word counter.
// Accept and delivery in the same cycle reload the slot so valid stays high.
module registrador_saida
  import demux_pkg::*;
#(
  parameter int LARGURA          = LARGURA_PADRAO,
  parameter int LARGURA_CONTADOR = LARGURA_CONTADOR_PADRAO
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        carregar,
  input  logic                        pronta,
  input  logic [LARGURA-1:0]          dado,
  output logic [LARGURA-1:0]          saida,
  output logic                        valida,
  output logic [LARGURA_CONTADOR-1:0] contagem
);

  logic entrega;
  assign entrega = valida && pronta;

  always_ff @(posedge clock) begin
    if (reset) begin
      saida    <= '0;
      valida   <= 1'b0;
      contagem <= '0;
    end else begin
      if (carregar) begin
        saida  <= dado;
        valida <= 1'b1;
      end else if (entrega) begin
        valida <= 1'b0;
      end
      // Free-running wrap, no saturation.
      if (entrega)
        contagem <= contagem + LARGURA_CONTADOR'(1);
    end
  end

endmodule

// File: rtl/demultiplexador_1x4_16b_hs.sv
// Registered 1-to-4 demultiplexer: the selector picks which slot loads the
// input word; input ready looks only at the selected slot.
module demultiplexador_1x4_16b_hs
  import demux_pkg::*;
#(
  parameter int LARGURA          = LARGURA_PADRAO,
  parameter int LARGURA_CONTADOR = LARGURA_CONTADOR_PADRAO
) (
  input logic                          clock,
  input logic                          reset,
  demultiplexador_1x4_16b_hs_if.slave  bus
);

  logic [NUM_SAIDAS-1:0]       valida_vec;
  logic [NUM_SAIDAS-1:0]       pronta_vec;
  logic [NUM_SAIDAS-1:0]       carregar_vec;
  logic [LARGURA-1:0]          dados_saida [NUM_SAIDAS];
  logic [LARGURA_CONTADOR-1:0] contagens   [NUM_SAIDAS];
  logic                        aceita;

  assign pronta_vec = {bus.saida_pronta_3, bus.saida_pronta_2,
                       bus.saida_pronta_1, bus.saida_pronta_0};

  // No path from entrada_valida into entrada_pronta.
  assign bus.entrada_pronta = !valida_vec[bus.entrada_controle] ||
                              pronta_vec[bus.entrada_controle];
  assign aceita       = bus.entrada_valida && bus.entrada_pronta;
  assign carregar_vec = {NUM_SAIDAS{aceita}} & decodificar(bus.entrada_controle);

  for (genvar k = 0; k < NUM_SAIDAS; k++) begin : g_slot
    registrador_saida #(
      .LARGURA          (LARGURA),
      .LARGURA_CONTADOR (LARGURA_CONTADOR)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .carregar (carregar_vec[k]),
      .pronta   (pronta_vec[k]),
      .dado     (bus.entrada),
      .saida    (dados_saida[k]),
      .valida   (valida_vec[k]),
      .contagem (contagens[k])
    );
  end

  assign bus.saida_0        = dados_saida[CANAL_0];
  assign bus.saida_1        = dados_saida[CANAL_1];
  assign bus.saida_2        = dados_saida[CANAL_2];
  assign bus.saida_3        = dados_saida[CANAL_3];
  assign bus.saida_valida_0 = valida_vec[CANAL_0];
  assign bus.saida_valida_1 = valida_vec[CANAL_1];
  assign bus.saida_valida_2 = valida_vec[CANAL_2];
  assign bus.saida_valida_3 = valida_vec[CANAL_3];
  assign bus.contagem_0     = contagens[CANAL_0];
  assign bus.contagem_1     = contagens[CANAL_1];
  assign bus.contagem_2     = contagens[CANAL_2];
  assign bus.contagem_3     = contagens[CANAL_3];

endmodule

// File: tb/tb_demultiplexador_1x4_16b_hs.sv
// Directed bench for the 1-to-4 demultiplexer: routing, back-pressure,
// streaming, counter wrap and reset, with a producer hold check.
module tb_demultiplexador_1x4_16b_hs;
  import demux_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] exp_q[$];
  logic [15:0] esperado;

  demultiplexador_1x4_16b_hs_if #(.LARGURA(16), .LARGURA_CONTADOR(8)) bus ();

  demultiplexador_1x4_16b_hs #(.LARGURA(16), .LARGURA_CONTADOR(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- observation views ----------------
  logic [15:0] s  [4];
  logic [7:0]  c  [4];
  logic [3:0]  sv;
  assign s[0] = bus.saida_0;
  assign s[1] = bus.saida_1;
  assign s[2] = bus.saida_2;
  assign s[3] = bus.saida_3;
  assign c[0] = bus.contagem_0;
  assign c[1] = bus.contagem_1;
  assign c[2] = bus.contagem_2;
  assign c[3] = bus.contagem_3;
  assign sv   = {bus.saida_valida_3, bus.saida_valida_2, bus.saida_valida_1, bus.saida_valida_0};

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] ctl, input logic [15:0] d);
    bus.entrada_valida   = v;
    bus.entrada_controle = ctl;
    bus.entrada          = d;
  endtask

  task automatic set_pronta(input logic [3:0] p);
    {bus.saida_pronta_3, bus.saida_pronta_2, bus.saida_pronta_1, bus.saida_pronta_0} = p;
  endtask

  // ---------------- producer hold check ----------------
  bit          protocolo_on;
  logic        pend_prev;
  logic [15:0] dado_prev;
  logic [1:0]  ctl_prev;
  initial pend_prev = 1'b0;
  always @(posedge clock) begin
    if (pend_prev && protocolo_on && !reset) begin
      check("protocolo_valida", 32'(bus.entrada_valida), 32'd1);
      check("protocolo_dado", 32'(bus.entrada), 32'(dado_prev));
      check("protocolo_controle", 32'(bus.entrada_controle), 32'(ctl_prev));
    end
    pend_prev = bus.entrada_valida && !bus.entrada_pronta && !reset;
    dado_prev = bus.entrada;
    ctl_prev  = bus.entrada_controle;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    protocolo_on = 1'b1;
    reset        = 1'b1;
    set_in(1'b0, 2'd0, 16'h0000);
    set_pronta(4'h0);

    // Reset and idle
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_valida_%0d", k), 32'(sv[k]), 32'd0);
      check($sformatf("reset_saida_%0d", k), 32'(s[k]), 32'h0);
      check($sformatf("reset_contagem_%0d", k), 32'(c[k]), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("pronta_pos_reset", 32'(bus.entrada_pronta), 32'd1);

    // Single routing, all consumers ready
    set_pronta(4'hF);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'(k), 16'(k + 1));
      #1;
      check($sformatf("rota_pronta_%0d", k), 32'(bus.entrada_pronta), 32'd1);
      tick();
      check($sformatf("rota_valida_%0d", k), 32'(sv[k]), 32'd1);
      check($sformatf("rota_saida_%0d", k), 32'(s[k]), 32'(k + 1));
    end
    set_in(1'b0, 2'd0, 16'h0000);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rota_esvazia_%0d", k), 32'(sv[k]), 32'd0);
      check($sformatf("rota_contagem_%0d", k), 32'(c[k]), 32'd1);
    end

    // Back-pressure isolation
    set_pronta(4'h0);
    set_in(1'b1, 2'd2, 16'hBEEF);
    tick();
    set_in(1'b1, 2'd2, 16'h1234);
    #1;
    check("bp_cheio_pronta", 32'(bus.entrada_pronta), 32'd0);
    check("bp_cheio_saida", 32'(s[2]), 32'hBEEF);
    tick();
    check("bp_mantem_saida", 32'(s[2]), 32'hBEEF);
    check("bp_mantem_valida", 32'(sv[2]), 32'd1);
    // The stalled word is deliberately retargeted to channel 1 here.
    protocolo_on = 1'b0;
    set_in(1'b1, 2'd1, 16'h1234);
    #1;
    check("bp_outro_pronta", 32'(bus.entrada_pronta), 32'd1);
    tick();
    protocolo_on = 1'b1;
    set_in(1'b0, 2'd0, 16'h0000);
    check("bp_outro_valida", 32'(sv[1]), 32'd1);
    check("bp_outro_saida", 32'(s[1]), 32'h1234);
    check("bp_isola_saida", 32'(s[2]), 32'hBEEF);
    set_pronta(4'hF);
    tick();
    check("bp_drena_valida1", 32'(sv[1]), 32'd0);
    check("bp_drena_valida2", 32'(sv[2]), 32'd0);
    check("bp_contagem1", 32'(c[1]), 32'd2);
    check("bp_contagem2", 32'(c[2]), 32'd2);

    // Simultaneous accept and delivery on channel 0, from clean counters
    reset = 1'b1;
    set_pronta(4'h0);
    tick();
    reset = 1'b0;
    set_in(1'b1, 2'd0, 16'hA000);
    exp_q.push_back(16'hA000);
    tick();
    set_pronta(4'h1);
    for (int i = 1; i < 10; i++) begin
      set_in(1'b1, 2'd0, 16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
      #1;
      check($sformatf("fluxo_pronta_%0d", i), 32'(bus.entrada_pronta), 32'd1);
      check($sformatf("fluxo_valida_%0d", i), 32'(sv[0]), 32'd1);
      check($sformatf("fluxo_contagem_%0d", i), 32'(c[0]), 32'(i - 1));
      esperado = exp_q.pop_front();
      check($sformatf("fluxo_saida_%0d", i), 32'(s[0]), 32'(esperado));
      tick();
    end
    set_in(1'b0, 2'd0, 16'h0000);
    check("fluxo_ultima_valida", 32'(sv[0]), 32'd1);
    esperado = exp_q.pop_front();
    check("fluxo_ultima_saida", 32'(s[0]), 32'(esperado));
    tick();
    check("fluxo_esvaziado", 32'(sv[0]), 32'd0);
    check("fluxo_contagem_final", 32'(c[0]), 32'd10);
    check("fluxo_fila_vazia", 32'(exp_q.size()), 32'd0);

    // Counter wrap on channel 3
    set_pronta(4'h8);
    for (int j = 0; j < 256; j++) begin
      set_in(1'b1, 2'd3, 16'(j));
      tick();
    end
    set_in(1'b0, 2'd0, 16'h0000);
    check("wrap_contagem_255", 32'(c[3]), 32'd255);
    tick();
    check("wrap_contagem_256", 32'(c[3]), 32'd0);
    check("wrap_valida", 32'(sv[3]), 32'd0);
    set_in(1'b1, 2'd3, 16'h0101);
    tick();
    set_in(1'b0, 2'd0, 16'h0000);
    tick();
    check("wrap_contagem_257", 32'(c[3]), 32'd1);
    check("wrap_dado_retido", 32'(s[3]), 32'h0101);

    // Reset mid-operation with all channels full
    set_pronta(4'h0);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'(k), 16'hC000 + 16'(k));
      tick();
    end
    set_in(1'b0, 2'd0, 16'h0000);
    check("cheio_todas_validas", 32'(sv), 32'hF);
    set_pronta(4'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_meio_valida_%0d", k), 32'(sv[k]), 32'd0);
      check($sformatf("rst_meio_contagem_%0d", k), 32'(c[k]), 32'd0);
      check($sformatf("rst_meio_saida_%0d", k), 32'(s[k]), 32'h0);
    end
    tick();
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_sem_entrega_%0d", k), 32'(c[k]), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
